// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
//   Shared definitions for the systolic-array front end.
//   - feed_state_e : state encoding of the operand feeder FSM
//   - FEED_CYC / DRAIN_CYC : skew-feed and drain lengths for the default
//     2x2 grid, plus helper functions that derive them for any N
// -----------------------------------------------------------------------------
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feed_state_e;

  localparam int N_DEFAULT = 2;

  // A skewed NxN feed takes 2N-1 cycles; the last operand then needs N-1
  // more hops to reach PE(N-1,N-1).
  localparam int FEED_CYC  = 2 * N_DEFAULT - 1;
  localparam int DRAIN_CYC = N_DEFAULT - 1;

  function automatic int feed_cyc(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_cyc(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Collects two NxN operand matrices (A then B, both row-major) from a host
//   stream, then drives them skewed into the west (a_lanes) and north
//   (b_lanes) edges of an NxN output-stationary PE grid.
//
//   Sequence: LOAD -> CLEAR (1) -> FEED (2N-1) -> DRAIN (N-1) -> DONE (1)
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : host operand valid
//   in_ready     : feeder accepts an operand this cycle
//   in_data      : operand value
//   flush        : synchronous abort back to LOAD
//   a_lanes      : row lanes to PE column 0, lane i at [i*WIDTH +: WIDTH]
//   b_lanes      : column lanes to PE row 0, lane j at [j*WIDTH +: WIDTH]
//   arr_clear    : accumulator clear to every PE
//   busy         : high during CLEAR, FEED and DRAIN
//   done         : one-cycle pulse, accumulators hold the final products
//
// Handshake: an operand transfers on a rising edge where in_valid and
// in_ready are both high; in_data must be stable while in_valid is high.
// in_ready depends only on registered state, never on in_valid.
//
// All grid-facing outputs are registered from the current state, so the
// visible phases (arr_clear, lanes, done) trail the state register by one
// cycle. in_ready is masked while done is still visible so that a new load
// never starts before the host has seen the pulse.
// -----------------------------------------------------------------------------
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic [N*WIDTH-1:0]   a_lanes,
  output logic [N*WIDTH-1:0]   b_lanes,
  output logic                 arr_clear,
  output logic                 busy,
  output logic                 done
);

  localparam int N_OPS     = 2 * N * N;
  localparam int LOAD_W    = $clog2(N_OPS);
  localparam int FEED_LEN  = feed_cyc(N);
  localparam int DRAIN_LEN = drain_cyc(N);
  localparam int CNT_W     = $clog2(FEED_LEN);

  localparam logic [LOAD_W-1:0] LOAD_LAST  = LOAD_W'(N_OPS - 1);
  localparam logic [CNT_W-1:0]  FEED_LAST  = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

  // B matrix starts right after the N*N entries of A.
  localparam int B_BASE = N * N;

  feed_state_e state_q, state_d;
  logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]  feed_cnt_q, feed_cnt_d;
  logic [WIDTH-1:0]  mem_q [N_OPS];
  logic [WIDTH-1:0]  mem_d [N_OPS];

  logic [N*WIDTH-1:0] a_lanes_q, a_lanes_d;
  logic [N*WIDTH-1:0] b_lanes_q, b_lanes_d;
  logic               arr_clear_q, arr_clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic in_hs;

  assign in_ready = (state_q == ST_LOAD) && !done_q;
  assign in_hs    = in_valid && in_ready;

  assign a_lanes   = a_lanes_q;
  assign b_lanes   = b_lanes_q;
  assign arr_clear = arr_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    mem_d       = mem_q;
    a_lanes_d   = '0;
    b_lanes_d   = '0;
    arr_clear_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          mem_d[load_cnt_q] = in_data;
          if (load_cnt_q == LOAD_LAST) begin
            state_d    = ST_CLEAR;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        arr_clear_d = 1'b1;
        busy_d      = 1'b1;
        state_d     = ST_FEED;
        feed_cnt_d  = '0;
      end

      ST_FEED: begin
        busy_d = 1'b1;
        // Row i is delayed by i cycles: at step t lane i carries A[i][t-i].
        // Column j likewise carries B[t-j][j]. Loops use constant indices
        // into storage and pick the single (i,k) pair that matches t.
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < N; k++) begin
            if (int'(feed_cnt_q) == i + k) begin
              a_lanes_d[i*WIDTH +: WIDTH] = mem_q[i*N + k];
            end
          end
        end
        for (int j = 0; j < N; j++) begin
          for (int r = 0; r < N; r++) begin
            if (int'(feed_cnt_q) == r + j) begin
              b_lanes_d[j*WIDTH +: WIDTH] = mem_q[B_BASE + r*N + j];
            end
          end
        end
        if (feed_cnt_q == FEED_LAST) begin
          state_d    = ST_DRAIN;
          feed_cnt_d = '0;
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        busy_d = 1'b1;
        if (feed_cnt_q == DRAIN_LAST) begin
          state_d    = ST_DONE;
          feed_cnt_d = '0;
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_LOAD;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Abort wins over everything, including a handshake in this cycle:
    // that operand is dropped and loading restarts at element 0.
    if (flush) begin
      state_d     = ST_LOAD;
      load_cnt_d  = '0;
      feed_cnt_d  = '0;
      mem_d       = mem_q;
      a_lanes_d   = '0;
      b_lanes_d   = '0;
      arr_clear_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      feed_cnt_q  <= '0;
      for (int i = 0; i < N_OPS; i++) begin
        mem_q[i] <= '0;
      end
      a_lanes_q   <= '0;
      b_lanes_q   <= '0;
      arr_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      for (int i = 0; i < N_OPS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      a_lanes_q   <= a_lanes_d;
      b_lanes_q   <= b_lanes_d;
      arr_clear_q <= arr_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule
